// File: rtl/iob_cpu_bus_arbiter.sv
// iob_cpu_bus_arbiter
//
// Shares one native iob memory port between the CPU instruction bus
// (master 0, read-only) and the data bus (master 1, read/write).
// Arbitration is registered: a request seen in IDLE is granted on the next
// cycle and held until the slave answers or the timeout aborts it. Each
// transaction is followed by one IDLE cycle.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   m0_*              ibus request (valid/addr) and response (ready/rdata)
//   m1_*              dbus request (valid/addr/wdata/wstrb) and response
//   s_*               shared slave port; s_ready is a single-cycle response
//   grant             one-hot current owner, 00 when idle
//   timeout_err       sticky flag, set when a transaction times out
module iob_cpu_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_EN     = 1,
  parameter int TIMEOUT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;

  // cnt counts BUSY cycles already spent, so the cycle that sees
  // cnt == CNT_MAX-1 is the (2^TIMEOUT_W-1)-th busy cycle: the terminal one.
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] CNT_TERM = CNT_MAX - TIMEOUT_W'(1);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic                 last_grant;   // 0 = master 0 was granted last
  logic [TIMEOUT_W-1:0] cnt;

  logic busy;
  logic terminal;
  logic done_ok;
  logic done_to;
  logic done;
  logic pick1;

  always_comb begin
    busy     = (state != IDLE);
    terminal = busy && (cnt == CNT_TERM);
    done_ok  = busy && s_ready;
    // A response on the terminal cycle wins over the abort.
    done_to  = terminal && !s_ready;
    done     = done_ok || done_to;
    // dbus wins when alone, under fixed priority, or when ibus had the last turn.
    pick1    = m1_valid && (!m0_valid || (RR_EN == 0) || !last_grant);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_valid || m1_valid) state_nxt = pick1 ? BUSY1 : BUSY0;
      end
      BUSY0, BUSY1: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && (state_nxt != IDLE)) last_grant <= (state_nxt == BUSY1);
      if (busy && !done) cnt <= cnt + TIMEOUT_W'(1);
      else               cnt <= '0;
      if (done_to) timeout_err <= 1'b1;
    end
  end

  // ---- combinational request mux and response routing ----
  always_comb begin
    grant    = {state == BUSY1, state == BUSY0};
    s_valid  = busy;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    if (state == BUSY0) s_addr = m0_addr;
    if (state == BUSY1) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end
    m0_ready = (state == BUSY0) && done;
    m1_ready = (state == BUSY1) && done;
    // rdata follows s_rdata only on a real response; a timeout returns 0.
    m0_rdata = ((state == BUSY0) && s_ready) ? s_rdata : '0;
    m1_rdata = ((state == BUSY1) && s_ready) ? s_rdata : '0;
  end

endmodule
